dm_arbiter: RTL and testbench

- Sequences every access to the 16-bit data memory and shares it between two requesters: the CPU MEM stage and a debug/loader port.
- Models memory access latency as WAIT_CYCLES, stalls the CPU pipeline until its access completes, and prevents starvation of the debug port.
- Sits between the MEM stage and the DM instance; the DM pins are driven only by this block.

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_wait_timer.sv | 36 +++
 rtl/dm_arbiter.sv | 150 +++++++++++++++
 tb/tb_dm_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and width constants for the data-memory arbiter
// Purpose : FSM state and owner encodings plus default data/address widths.
// Ports   : none (package).
package dm_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/dm_wait_timer.sv
// rtl/dm_wait_timer.sv - wait-state counter that flags the last ACCESS cycle
// Purpose : counts cycles spent in ACCESS; last is high while the count equals WAIT_CYCLES-1.
// Ports   : clk, rst_n (sync, active-low)
//           clr  - zero the count (takes priority over en)
//           en   - advance the count by one
//           last - current cycle is the final wait cycle
module dm_wait_timer
    import dm_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    // Wide enough to hold WAIT_CYCLES itself, the value the count lands on in RESP.
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] wcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (clr) begin
            wcnt <= '0;
        end else if (en) begin
            wcnt <= wcnt + CNT_W'(1);
        end
    end

    assign last = (wcnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - shares the data memory between the CPU MEM stage and a debug port
// Purpose : arbitrates CPU vs debug, models WAIT_CYCLES memory latency, stalls the CPU until
//           its access completes and forces a debug win after STARVE_LIMIT consecutive CPU wins.
// Ports   : clk, rst_n (sync, active-low)
//           cpu_re/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//           dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_gnt, dbg_done, dbg_rdata
//           dm_addr/dm_re/dm_we/dm_wdata -> DM, dm_rdata <- DM
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W       = dm_arb_pkg::DATA_W,
    parameter int ADDR_W       = dm_arb_pkg::ADDR_W,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_re,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t            state, state_next;
    owner_t            owner, owner_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] wdata_q, wdata_next;
    logic              we_q, we_next;
    logic [SW-1:0]     starve_cnt, starve_next;
    logic              timer_clr, timer_en, timer_last;
    logic              capture;
    logic              cpu_req, dbg_win;

    dm_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr),
        .en   (timer_en),
        .last (timer_last)
    );

    assign cpu_req = cpu_re | cpu_we;
    // Debug takes the slot if it is alone or the CPU has used up its consecutive-win allowance.
    assign dbg_win = dbg_req & (~cpu_req | (starve_cnt == SW'(STARVE_LIMIT)));

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        addr_next   = addr_q;
        wdata_next  = wdata_q;
        we_next     = we_q;
        starve_next = starve_cnt;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req | dbg_req) begin
                    owner_next = dbg_win ? OWN_DBG : OWN_CPU;
                    addr_next  = dbg_win ? dbg_addr : cpu_addr;
                    wdata_next = dbg_win ? dbg_wdata : cpu_wdata;
                    // cpu_re and cpu_we together count as a write.
                    we_next    = dbg_win ? dbg_we : cpu_we;
                    timer_clr  = 1'b1;
                    state_next = ACCESS;
                end
                if (!dbg_req || dbg_win) begin
                    starve_next = '0;
                end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                    starve_next = starve_cnt + SW'(1);
                end
            end
            ACCESS: begin
                timer_en = 1'b1;
                if (timer_last) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // DM strobes, grant and done are registered from the next state so they line up
    // exactly with the ACCESS / RESP cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
            dm_re      <= 1'b0;
            dm_we      <= 1'b0;
            dbg_gnt    <= 1'b0;
            dbg_done   <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            we_q       <= we_next;
            starve_cnt <= starve_next;
            dm_re      <= (state_next == ACCESS) && !we_next;
            dm_we      <= (state_next == ACCESS) && we_next;
            dbg_gnt    <= (state_next == ACCESS) && (owner_next == OWN_DBG);
            dbg_done   <= (state_next == RESP) && (owner_next == OWN_DBG);
            if (capture && !we_q) begin
                if (owner == OWN_DBG) begin
                    dbg_rdata <= dm_rdata;
                end else begin
                    cpu_rdata <= dm_rdata;
                end
            end
        end
    end

    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;

    // Combinational so the pipeline freezes in the same cycle the request appears.
    assign cpu_stall = cpu_req & ~((state == RESP) & (owner == OWN_CPU));

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter against a transaction-timeline model
module tb_dm_arbiter;

    localparam int W = 2;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_done;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_re, dm_we;

    always #5 clk = ~clk;

    dm_arbiter #(
        .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(W), .STARVE_LIMIT(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    function automatic logic [15:0] init_pat(input logic [15:0] a);
        logic [15:0] v;
        v = a * 16'h9E37;
        v = v ^ 16'h5A5A;
        if (a == 16'h0010) v = 16'hBEEF;
        return v;
    endfunction

    // Data memory: asynchronous read, write on the clock edge while dm_we is high.
    logic        pl_en;
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_pat(16'(i));
        end else if (dm_we) begin
            mem[dm_addr[7:0]] <= dm_wdata;
        end
    end
    assign dm_rdata = mem[dm_addr[7:0]];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: one transaction at a time, placed on a cycle timeline.
    // Granted in IDLE cycle t_start: ACCESS is t_start+1..t_start+W, RESP is t_start+W+1.
    int          cyc = 0;
    bit          busy = 0;
    int          t_start = 0;
    bit          m_dbg = 0, m_we = 0;
    logic [15:0] m_addr = '0, m_wdata = '0;
    int          starve = 0;
    logic [15:0] shadow [256];
    logic [15:0] exp_cpu_rd = '0, exp_dbg_rd = '0;

    int n_stall = 0, n_re = 0, n_we = 0, n_gnt = 0, n_done = 0;
    bit prev_acc = 0;
    bit dut_grants[$];
    bit exp_order[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int phase();
        return busy ? (cyc - t_start) : 0;
    endfunction

    task automatic model_edge();
        bit creq, dwin;
        creq = cpu_re | cpu_we;
        if (!rst_n) begin
            busy = 0; starve = 0; exp_cpu_rd = '0; exp_dbg_rd = '0;
            return;
        end
        if (busy) begin
            if (phase() == W + 1) begin
                busy = 0;
            end else if (phase() == W) begin
                if (m_we) shadow[m_addr[7:0]] = m_wdata;
                else if (m_dbg) exp_dbg_rd = shadow[m_addr[7:0]];
                else exp_cpu_rd = shadow[m_addr[7:0]];
            end
        end else begin
            dwin = dbg_req && (!creq || starve == L);
            if (creq || dbg_req) begin
                busy = 1; t_start = cyc; m_dbg = dwin;
                m_we    = dwin ? dbg_we    : cpu_we;
                m_addr  = dwin ? dbg_addr  : cpu_addr;
                m_wdata = dwin ? dbg_wdata : cpu_wdata;
            end
            if (!dbg_req || dwin) starve = 0;
            else starve = (starve < L) ? starve + 1 : L;
        end
    endtask

    task automatic check_stall();
        bit exp_s;
        exp_s = (cpu_re | cpu_we) && !(busy && phase() == W + 1 && !m_dbg);
        chk("cpu_stall", cpu_stall, exp_s);
    endtask

    task automatic check_regs();
        int p;
        bit acc, resp, acc_now;
        p = phase();
        acc = busy && p >= 1 && p <= W;
        resp = busy && p == W + 1;
        chk("dm_re", dm_re, acc && !m_we);
        chk("dm_we", dm_we, acc && m_we);
        chk("dbg_gnt", dbg_gnt, acc && m_dbg);
        chk("dbg_done", dbg_done, resp && m_dbg);
        if (acc) begin
            chk("dm_addr", dm_addr, m_addr);
            chk("dm_wdata", dm_wdata, m_wdata);
        end
        chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
        chk("dbg_rdata", dbg_rdata, exp_dbg_rd);
        if (dm_re === 1'b1) n_re++;
        if (dm_we === 1'b1) n_we++;
        if (dbg_gnt === 1'b1) n_gnt++;
        if (dbg_done === 1'b1) n_done++;
        acc_now = (dm_re === 1'b1) || (dm_we === 1'b1);
        if (acc_now && !prev_acc) dut_grants.push_back(dbg_gnt === 1'b1);
        prev_acc = acc_now;
    endtask

    task automatic step();
        #1;
        check_stall();
        if (cpu_stall === 1'b1) n_stall++;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_regs();
    endtask

    task automatic cpu_access(input bit re, input bit we, input logic [15:0] a, input logic [15:0] d);
        bit done;
        done = 0;
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (busy && !m_dbg && phase() == W + 1) begin
                #1;
                check_stall();
                done = 1;
            end
        end
        chk("cpu_access_timeout", done, 1);
        cpu_re = 0; cpu_we = 0;
    endtask

    task automatic dbg_access(input bit we, input logic [15:0] a, input logic [15:0] d, input bit hold);
        bit done;
        done = 0;
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (busy && m_dbg && phase() == 1 && !hold) begin
                dbg_req = 0; dbg_we = ~we; dbg_addr = ~a; dbg_wdata = ~d;
            end
            if (busy && m_dbg && phase() == W + 1) begin
                dbg_req = 0;
                done = 1;
            end
        end
        chk("dbg_access_timeout", done, 1);
    endtask

    initial begin
        bit c_act, d_act, d_hold;
        int k;
        c_act = 0; d_act = 0; d_hold = 0;
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 1;
        exp_order[3] = 0; exp_order[4] = 0; exp_order[5] = 1;

        rst_n = 0; pl_en = 1;
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = init_pat(16'(i));
        step();
        pl_en = 0;
        step();
        step();

        // Reset state
        chk("rst_dm_addr", dm_addr, 16'h0000);
        chk("rst_dm_wdata", dm_wdata, 16'h0000);
        chk("rst_dm_re", dm_re, 1'b0);
        chk("rst_dm_we", dm_we, 1'b0);
        chk("rst_dbg_gnt", dbg_gnt, 1'b0);
        chk("rst_dbg_done", dbg_done, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        chk("rst_dbg_rdata", dbg_rdata, 16'h0000);
        cpu_re = 1;
        #1;
        chk("rst_cpu_stall", cpu_stall, 1'b1);
        cpu_re = 0;
        rst_n = 1;
        step();

        // CPU read only
        n_stall = 0; n_re = 0;
        cpu_access(1, 0, 16'h0010, 16'h0000);
        chk("t1_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_stall_cycles", n_stall, 3);
        chk("t1_re_cycles", n_re, 2);
        step();

        // Debug write only, then CPU read-back
        n_gnt = 0; n_we = 0; n_done = 0;
        dbg_access(1, 16'h0020, 16'h1234, 0);
        chk("t2_gnt_cycles", n_gnt, 2);
        chk("t2_we_cycles", n_we, 2);
        chk("t2_done_pulses", n_done, 1);
        step();
        chk("t2_done_width", dbg_done, 1'b0);
        cpu_access(1, 0, 16'h0020, 16'h0000);
        chk("t2_readback", cpu_rdata, 16'h1234);
        step();

        // Contention: both request in every IDLE
        dut_grants.delete(); n_done = 0;
        cpu_re = 1; cpu_we = 0; cpu_addr = 16'h0030;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0040;
        repeat (24) step();
        cpu_re = 0; dbg_req = 0;
        step();
        chk("t3_grant_count", dut_grants.size(), 6);
        for (int i = 0; i < 6 && i < dut_grants.size(); i++)
            chk($sformatf("t3_grant%0d", i), dut_grants[i], exp_order[i]);
        chk("t3_done_pulses", n_done, 2);

        // cpu_re and cpu_we together: write, read data held
        n_re = 0; n_we = 0;
        cpu_access(1, 1, 16'h0050, 16'h00FF);
        chk("t4_re_cycles", n_re, 0);
        chk("t4_we_cycles", n_we, 2);
        chk("t4_rdata_held", cpu_rdata, init_pat(16'h0030));
        step();
        dbg_access(0, 16'h0050, 16'h0000, 1);
        chk("t4_written", dbg_rdata, 16'h00FF);
        step();

        // Reset on the second ACCESS cycle of a debug read
        n_done = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0010;
        step();
        dbg_req = 0;
        step();
        chk("t5_in_access", dm_re, 1'b1);
        rst_n = 0;
        step();
        chk("t5_rst_re", dm_re, 1'b0);
        chk("t5_rst_gnt", dbg_gnt, 1'b0);
        chk("t5_rst_rdata", dbg_rdata, 16'h0000);
        rst_n = 1;
        step(); step(); step();
        chk("t5_no_done", n_done, 0);

        // dbg_req dropped right after grant
        n_done = 0;
        dbg_access(0, 16'h0020, 16'h0000, 0);
        chk("t6_done", n_done, 1);
        chk("t6_rdata", dbg_rdata, 16'h1234);
        step();
        dut_grants.delete();
        cpu_re = 1; cpu_addr = 16'h0031;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0041;
        repeat (12) step();
        cpu_re = 0; dbg_req = 0;
        step();
        chk("t6_grant_count", dut_grants.size(), 3);
        for (int i = 0; i < 3 && i < dut_grants.size(); i++)
            chk($sformatf("t6_grant%0d", i), dut_grants[i], exp_order[i]);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (!c_act && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 2);
                cpu_re = (k != 1); cpu_we = (k != 0);
                cpu_addr = 16'($urandom_range(0, 31)); cpu_wdata = 16'($urandom);
                c_act = 1;
            end
            if (!d_act && $urandom_range(0, 3) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 16'($urandom_range(0, 31)); dbg_wdata = 16'($urandom);
                d_hold = 1'($urandom_range(0, 1));
                d_act = 1;
            end
            step();
            if (c_act && busy && !m_dbg && phase() == W + 1) begin
                #1;
                check_stall();
                cpu_re = 0; cpu_we = 0; c_act = 0;
            end
            if (d_act && busy && m_dbg && phase() == 1 && !d_hold) begin
                dbg_req = 0; dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
            end
            if (d_act && busy && m_dbg && phase() == W + 1) begin
                dbg_req = 0; d_act = 0;
            end
        end
        cpu_re = 0; cpu_we = 0; dbg_req = 0;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
